fighter_motion: RTL and testbench



---
 rtl/fighter_pkg.sv | 40 ++++
 rtl/frame_input_sync.sv | 57 +++++
 rtl/fighter_motion.sv | 192 +++++++++++++++++++
 tb/tb_fighter_motion.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fighter_pkg.sv
// fighter_pkg
//   Shared types and constants for the per-player motion controller.
//   - phase_t   : motion phase (GROUND, AIR, DIVE)
//   - POSE_*    : pose codes handed to the renderer; BACK_OFFSET selects the
//                 back-facing sprite set
//   - FIGHTER_W/H, SCREEN_W, FLOOR_Y : playfield geometry in pixels
//   - vel_t     : 11-bit signed velocity / position-sum type
//   - pose_of() : phase + facing -> pose code
package fighter_pkg;

    typedef enum logic [1:0] {
        GROUND = 2'd0,
        AIR    = 2'd1,
        DIVE   = 2'd2
    } phase_t;

    localparam logic [2:0] POSE_GROUND = 3'd0;
    localparam logic [2:0] POSE_JUMP   = 3'd1;
    localparam logic [2:0] POSE_KICK   = 3'd2;
    localparam logic [2:0] BACK_OFFSET = 3'd3;

    localparam int FIGHTER_W = 72;
    localparam int FIGHTER_H = 105;
    localparam int SCREEN_W  = 640;
    localparam int FLOOR_Y   = 429;

    typedef logic signed [10:0] vel_t;

    // back = facing_left XOR MIRROR; codes 6 and 7 can never come out.
    function automatic logic [2:0] pose_of(input phase_t ph, input logic back);
        logic [2:0] p;
        case (ph)
            AIR:     p = POSE_JUMP;
            DIVE:    p = POSE_KICK;
            default: p = POSE_GROUND;
        endcase
        return back ? p + BACK_OFFSET : p;
    endfunction

endpackage

// File: rtl/frame_input_sync.sv
// frame_input_sync
//   Brings the asynchronous frame strobe into the Clk domain and latches
//   button presses until the next frame tick.
//   Ports:
//     Clk, Reset        : clock, synchronous active-high reset
//     Restart           : round restart, clears pending presses
//     Freeze            : hit-freeze, clears pending presses every Clk
//     frame_clk         : ~60 Hz asynchronous frame strobe
//     key_jump/key_kick : button levels (Clk domain)
//     tick              : one-Clk pulse on each frame_clk rising edge
//     jump_pend/kick_pend : press seen since the last tick
module frame_input_sync (
    input  logic Clk,
    input  logic Reset,
    input  logic Restart,
    input  logic Freeze,
    input  logic frame_clk,
    input  logic key_jump,
    input  logic key_kick,
    output logic tick,
    output logic jump_pend,
    output logic kick_pend
);

    // [0],[1] are the two synchronizer flops, [2] holds the previous value
    // for edge detection.
    logic [2:0] frame_sr;
    logic       jump_q;
    logic       kick_q;

    assign tick = frame_sr[1] & ~frame_sr[2];

    always_ff @(posedge Clk) begin
        if (Reset) begin
            frame_sr <= 3'b000;
            jump_q   <= 1'b0;
            kick_q   <= 1'b0;
        end else begin
            frame_sr <= {frame_sr[1:0], frame_clk};
            jump_q   <= key_jump;
            kick_q   <= key_kick;
        end
    end

    // A tick consumes the flags; a press landing on the tick cycle itself
    // is kept for the following frame.
    always_ff @(posedge Clk) begin
        if (Reset || Restart || Freeze) begin
            jump_pend <= 1'b0;
            kick_pend <= 1'b0;
        end else begin
            jump_pend <= (jump_pend & ~tick) | (key_jump & ~jump_q);
            kick_pend <= (kick_pend & ~tick) | (key_kick & ~kick_q);
        end
    end

endmodule

// File: rtl/fighter_motion.sv
// fighter_motion
//   Per-player motion controller: frame-synchronous button presses become a
//   pose code plus the top-left sprite position.
//   Ports:
//     Clk, Reset        : clock, synchronous active-high reset
//     frame_clk         : asynchronous frame strobe (synchronized inside)
//     Restart           : one-Clk round restart, re-spawns immediately
//     Freeze            : hit-freeze from the renderer, holds all motion
//     key_jump/key_kick : button levels
//     opp_X_Pos         : opponent X, decides facing while on the ground
//     state             : pose code (0..5)
//     X_Pos/Y_Pos       : sprite top-left position
//     airborne          : high in AIR or DIVE
//   Build option FIGHTER_HOLD_JUMP_EN: holding jump while rising halves the
//   gravity rate (applied every other frame) for a higher jump.
module fighter_motion
    import fighter_pkg::*;
#(
    parameter int START_X         = 100,
    parameter int START_FACE_LEFT = 0,
    parameter int MIRROR          = 0,
    parameter int GROUND_Y        = FLOOR_Y - FIGHTER_H,
    parameter int X_MIN           = 0,
    parameter int X_MAX           = SCREEN_W - FIGHTER_W,
    parameter int JUMP_VEL        = 12,
    parameter int HOP_VX          = 4,
    parameter int HOP_VY          = 8,
    parameter int DIVE_VX         = 6,
    parameter int DIVE_VY         = 6,
    parameter int GRAVITY         = 1
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_clk,
    input  logic       Restart,
    input  logic       Freeze,
    input  logic       key_jump,
    input  logic       key_kick,
    input  logic [9:0] opp_X_Pos,
    output logic [2:0] state,
    output logic [9:0] X_Pos,
    output logic [9:0] Y_Pos,
    output logic       airborne
);

    localparam vel_t X_MIN_S    = vel_t'(X_MIN);
    localparam vel_t X_MAX_S    = vel_t'(X_MAX);
    localparam vel_t GROUND_Y_S = vel_t'(GROUND_Y);
    localparam vel_t ZERO_V     = '0;

    logic   tick, jump_pend, kick_pend;
    phase_t phase, n_phase;
    logic   facing_left, n_face;
    vel_t   vx, vy, n_vx, n_vy;
    logic [9:0] n_x, n_y;

    vel_t   x_sum, y_sum, vx_cl, grav;
    logic [9:0] x_cl, y_cl;
    logic   land;

`ifdef FIGHTER_HOLD_JUMP_EN
    logic grav_tog, n_tog;
`endif

    frame_input_sync u_sync (
        .Clk       (Clk),
        .Reset     (Reset),
        .Restart   (Restart),
        .Freeze    (Freeze),
        .frame_clk (frame_clk),
        .key_jump  (key_jump),
        .key_kick  (key_kick),
        .tick      (tick),
        .jump_pend (jump_pend),
        .kick_pend (kick_pend)
    );

    // Candidate moves, computed in 11-bit signed so under/overflow is visible.
    always_comb begin
        x_sum = vel_t'({1'b0, X_Pos}) + vx;
        y_sum = vel_t'({1'b0, Y_Pos}) + vy;

        x_cl  = x_sum[9:0];
        vx_cl = vx;
        if (x_sum < X_MIN_S) begin
            x_cl  = 10'(X_MIN);
            vx_cl = '0;
        end else if (x_sum > X_MAX_S) begin
            x_cl  = 10'(X_MAX);
            vx_cl = '0;
        end

        y_cl = (y_sum < ZERO_V) ? 10'd0 : y_sum[9:0];
        land = (phase != GROUND) && (vy > ZERO_V) && (y_sum >= GROUND_Y_S);
    end

    always_comb begin
        n_phase = phase;
        n_face  = facing_left;
        n_vx    = vx;
        n_vy    = vy;
        n_x     = X_Pos;
        n_y     = Y_Pos;
        grav    = vel_t'(GRAVITY);
`ifdef FIGHTER_HOLD_JUMP_EN
        n_tog   = grav_tog;
        if (phase == AIR && vy < ZERO_V && key_jump) begin
            if (!grav_tog)
                grav = '0;
            n_tog = ~grav_tog;
        end
`endif

        case (phase)
            GROUND: begin
                // Equal X keeps the current facing.
                if (opp_X_Pos < X_Pos)
                    n_face = 1'b1;
                else if (opp_X_Pos > X_Pos)
                    n_face = 1'b0;

                if (jump_pend) begin
                    n_phase = AIR;
                    n_vx    = '0;
                    n_y     = Y_Pos - 10'(JUMP_VEL);
                    n_vy    = vel_t'(GRAVITY - JUMP_VEL);
`ifdef FIGHTER_HOLD_JUMP_EN
                    n_tog   = 1'b0;
`endif
                end else if (kick_pend) begin
                    // Back-hop travels away from the opponent.
                    n_phase = AIR;
                    n_vx    = n_face ? vel_t'(HOP_VX) : -vel_t'(HOP_VX);
                    n_y     = Y_Pos - 10'(HOP_VY);
                    n_vy    = vel_t'(GRAVITY - HOP_VY);
`ifdef FIGHTER_HOLD_JUMP_EN
                    n_tog   = 1'b0;
`endif
                end
            end
            AIR, DIVE: begin
                if (land) begin
                    n_phase = GROUND;
                    n_x     = x_cl;
                    n_y     = 10'(GROUND_Y);
                    n_vx    = '0;
                    n_vy    = '0;
                end else if (phase == AIR && kick_pend) begin
                    n_phase = DIVE;
                    n_vx    = facing_left ? -vel_t'(DIVE_VX) : vel_t'(DIVE_VX);
                    n_vy    = vel_t'(DIVE_VY);
                end else begin
                    n_x  = x_cl;
                    n_vx = vx_cl;
                    n_y  = y_cl;
                    if (phase == AIR)
                        n_vy = vy + grav;
                end
            end
            default: n_phase = GROUND;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset || Restart) begin
            phase       <= GROUND;
            facing_left <= (START_FACE_LEFT != 0);
            vx          <= '0;
            vy          <= '0;
            X_Pos       <= 10'(START_X);
            Y_Pos       <= 10'(GROUND_Y);
            state       <= pose_of(GROUND, (START_FACE_LEFT != 0) ^ (MIRROR != 0));
            airborne    <= 1'b0;
`ifdef FIGHTER_HOLD_JUMP_EN
            grav_tog    <= 1'b0;
`endif
        end else if (tick && !Freeze) begin
            phase       <= n_phase;
            facing_left <= n_face;
            vx          <= n_vx;
            vy          <= n_vy;
            X_Pos       <= n_x;
            Y_Pos       <= n_y;
            state       <= pose_of(n_phase, n_face ^ (MIRROR != 0));
            airborne    <= (n_phase != GROUND);
`ifdef FIGHTER_HOLD_JUMP_EN
            grav_tog    <= n_tog;
`endif
        end
    end

endmodule

// File: tb/tb_fighter_motion.sv
// tb_fighter_motion
//   Directed scenarios plus randomized frames for fighter_motion (default
//   parameters), checked against a plain-arithmetic reference model through
//   an expected-value queue drained by an independent monitor.
module tb_fighter_motion;

    localparam int GY = 324, XMIN = 0, XMAX = 568, SX = 100;
    localparam int JV = 12, HVX = 4, HVY = 8, DVX = 6, DVY = 6, G = 1;

    logic       Clk = 1'b0;
    logic       Reset, frame_clk, Restart, Freeze, key_jump, key_kick;
    logic [9:0] opp_X_Pos;
    logic [2:0] state;
    logic [9:0] X_Pos, Y_Pos;
    logic       airborne;

    fighter_motion dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .frame_clk (frame_clk),
        .Restart   (Restart),
        .Freeze    (Freeze),
        .key_jump  (key_jump),
        .key_kick  (key_kick),
        .opp_X_Pos (opp_X_Pos),
        .state     (state),
        .X_Pos     (X_Pos),
        .Y_Pos     (Y_Pos),
        .airborne  (airborne)
    );

    always #10 Clk = ~Clk;

    // Scoreboard: {state, X, Y, airborne}
    logic [23:0] exp_q[$];
    int vectors = 0;
    int miscompares = 0;

    // Reference model: phase 0 ground, 1 air, 2 dive.
    int m_x, m_y, m_vx, m_vy, m_ph;
    bit m_fl, m_pj, m_pk;

    task automatic clks(input int n);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    task automatic model_reset();
        m_x = SX; m_y = GY; m_vx = 0; m_vy = 0; m_ph = 0;
        m_fl = 1'b0; m_pj = 1'b0; m_pk = 1'b0;
    endtask

    task automatic push_expect();
        logic [2:0] p;
        logic [9:0] ex, ey;
        p  = 3'((m_fl ? 3 : 0) + m_ph);
        ex = 10'(m_x);
        ey = 10'(m_y);
        exp_q.push_back({p, ex, ey, (m_ph != 0)});
    endtask

    task automatic move_x();
        int nx;
        nx = m_x + m_vx;
        if (nx < XMIN) begin
            nx = XMIN; m_vx = 0;
        end else if (nx > XMAX) begin
            nx = XMAX; m_vx = 0;
        end
        m_x = nx;
    endtask

    task automatic model_step(input int opp);
        if (m_ph == 0) begin
            if (opp < m_x) m_fl = 1'b1;
            else if (opp > m_x) m_fl = 1'b0;
            if (m_pj) begin
                m_ph = 1; m_vx = 0; m_y = m_y - JV; m_vy = G - JV;
            end else if (m_pk) begin
                m_ph = 1; m_vx = m_fl ? HVX : -HVX; m_y = m_y - HVY; m_vy = G - HVY;
            end
        end else if (m_vy > 0 && m_y + m_vy >= GY) begin
            move_x();
            m_y = GY; m_vx = 0; m_vy = 0; m_ph = 0;
        end else if (m_ph == 1 && m_pk) begin
            m_ph = 2; m_vx = m_fl ? -DVX : DVX; m_vy = DVY;
        end else begin
            move_x();
            m_y = (m_y + m_vy < 0) ? 0 : m_y + m_vy;
            if (m_ph == 1) m_vy = m_vy + G;
        end
        m_pj = 1'b0;
        m_pk = 1'b0;
    endtask

    task automatic press(input bit j, input bit k);
        key_jump = j;
        key_kick = k;
        clks(2);
        key_jump = 1'b0;
        key_kick = 1'b0;
        clks(1);
        if (!Freeze) begin
            m_pj = m_pj | j;
            m_pk = m_pk | k;
        end
    endtask

    task automatic frame();
        frame_clk = 1'b1;
        clks(5);
        frame_clk = 1'b0;
        clks(3);
        if (!Freeze) model_step(int'(opp_X_Pos));
        push_expect();
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) frame();
    endtask

    task automatic frames_until_ground();
        for (int i = 0; i < 40 && m_ph != 0; i++) frame();
        frame();
    endtask

    task automatic set_freeze(input bit v);
        Freeze = v;
        if (v) begin
            m_pj = 1'b0;
            m_pk = 1'b0;
        end
        clks(1);
    endtask

    task automatic restart_pulse();
        Restart = 1'b1;
        clks(1);
        Restart = 1'b0;
        model_reset();
        push_expect();
    endtask

    // Monitor: outputs are stable by the time an expectation is queued.
    initial begin
        logic [23:0] e, a;
        forever begin
            @(negedge Clk);
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = {state, X_Pos, Y_Pos, airborne};
                vectors++;
                if (a !== e) begin
                    miscompares++;
                    $display("FAIL motion #%0d: got state=%0d X=%0d Y=%0d air=%0b, want state=%0d X=%0d Y=%0d air=%0b",
                             vectors, a[23:21], a[20:11], a[10:1], a[0],
                             e[23:21], e[20:11], e[10:1], e[0]);
                end
            end
        end
    end

    initial begin
        int r;
        bit fz;
        Reset = 1'b1; Restart = 1'b0; Freeze = 1'b0; frame_clk = 1'b0;
        key_jump = 1'b0; key_kick = 1'b0; opp_X_Pos = 10'd400;
        model_reset();
        clks(3);
        Reset = 1'b0;
        clks(1);
        push_expect();

        // Straight jump, full arc.
        press(1, 0);
        frames(26);

        // Jump, then dive after the third frame.
        press(1, 0);
        frames(3);
        press(0, 1);
        frames_until_ground();

        // Back-hop facing left.
        opp_X_Pos = 10'd50;
        frame();
        press(0, 1);
        frames(18);

        // Hop repeatedly rightwards into the right wall.
        opp_X_Pos = 10'd0;
        for (int i = 0; i < 8; i++) begin
            press(0, 1);
            frames(18);
        end

        // At the wall facing right: jump then dive into the clamp.
        opp_X_Pos = 10'd1000;
        press(1, 0);
        frames(3);
        press(0, 1);
        frames_until_ground();

        // Hop leftwards into the left wall.
        for (int i = 0; i < 10; i++) begin
            press(0, 1);
            frames(18);
        end

        // Freeze mid-jump with a kick pressed while frozen.
        opp_X_Pos = 10'd400;
        press(1, 0);
        frames(5);
        set_freeze(1);
        press(0, 1);
        frames(10);
        set_freeze(0);
        frames_until_ground();

        // Simultaneous presses give a jump; then Restart while airborne.
        press(1, 1);
        frames(3);
        restart_pulse();

        // Randomized frames.
        for (int i = 0; i < 300; i++) begin
            opp_X_Pos = 10'($urandom_range(0, 639));
            r = $urandom_range(0, 99);
            if (r < 3) begin
                restart_pulse();
            end else begin
                if (r < 30) press(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
                fz = (r >= 90);
                if (fz) set_freeze(1);
                frame();
                if (fz) set_freeze(0);
            end
        end

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge Clk);
        if (exp_q.size() > 0) begin
            miscompares++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
